// File: rtl/riscv_trap_ctrl_if.sv
// Bus bundle between the pipeline (master) and the trap controller (slave).
// The nmi/mnmivec signals exist only when RISCV_NMI_EN is defined.
interface riscv_trap_ctrl_if #(
   parameter int XLEN = 32
);
   // Pipeline event inputs
   logic            exc_valid;
   logic [3:0]      exc_cause;
   logic [XLEN-1:0] exc_pc;
   logic [XLEN-1:0] exc_tval;
   logic            mret_valid;
   logic [11:0]     irq_pending;
`ifdef RISCV_NMI_EN
   logic            nmi;
   logic [XLEN-1:0] mnmivec;
`endif

   // Current architectural state
   logic            mstatus_mie;
   logic            mstatus_mpie;
   logic [1:0]      mstatus_mpp;
   logic [1:0]      priv;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;

   // Handshakes and CSR write-back
   logic            evt_ready;
   logic            flush;
   logic            drained;
   logic            csr_we;
   logic [XLEN-1:0] mepc_d;
   logic [XLEN-1:0] mcause_d;
   logic [XLEN-1:0] mtval_d;
   logic            mie_d;
   logic            mpie_d;
   logic [1:0]      mpp_d;
   logic [1:0]      priv_d;
   logic            redir_valid;
   logic [XLEN-1:0] redir_pc;
   logic            redir_ready;

   modport slave (
      input
`ifdef RISCV_NMI_EN
         nmi, mnmivec,
`endif
         exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, irq_pending,
         mstatus_mie, mstatus_mpie, mstatus_mpp, priv, mtvec, mepc,
         drained, redir_ready,
      output
         evt_ready, flush, csr_we, mepc_d, mcause_d, mtval_d,
         mie_d, mpie_d, mpp_d, priv_d, redir_valid, redir_pc
   );

   modport master (
      output
`ifdef RISCV_NMI_EN
         nmi, mnmivec,
`endif
         exc_valid, exc_cause, exc_pc, exc_tval, mret_valid, irq_pending,
         mstatus_mie, mstatus_mpie, mstatus_mpp, priv, mtvec, mepc,
         drained, redir_ready,
      input
         evt_ready, flush, csr_we, mepc_d, mcause_d, mtval_d,
         mie_d, mpie_d, mpp_d, priv_d, redir_valid, redir_pc
   );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap controller: accepts an exception, MRET, interrupt (or
// NMI when RISCV_NMI_EN is defined), flushes the pipeline, issues a single
// CSR write strobe and then redirects fetch.
// Sequence: IDLE -> DRAIN (flush until drained) -> COMMIT (csr_we) -> REDIR.
// PC_INIT is the redirect target whenever no trap vector applies (the NMI
// slot in builds without RISCV_NMI_EN).
module riscv_trap_ctrl #(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
   input logic               clk,
   input logic               rstn,
   riscv_trap_ctrl_if.slave  bus
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("riscv_trap_ctrl: XLEN must be 32 or 64");
   end

   localparam logic [1:0]  PRV_U    = 2'd0;
   localparam logic [1:0]  PRV_M    = 2'd3;
   // Implemented interrupt bits: USI SSI MSI UTI STI MTI UEI SEI MEI
   localparam logic [11:0] IRQ_MASK = 12'hBBB;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIR} state_t;
   typedef enum logic [1:0] {EV_EXC, EV_MRET, EV_IRQ, EV_NMI}     event_t;

   state_t          state_q, state_d;
   event_t          ev_q, ev_sel;
   logic            evt_take;
   logic            nmi_req;
   logic [11:0]     irq_live;
   logic            irq_take;
   logic [3:0]      irq_cause;
   logic [3:0]      cause_q;
   logic [XLEN-1:0] pc_q, tval_q;
   logic [XLEN-1:0] target_q, target_d;
   logic [XLEN-1:0] vec_base;
   logic [XLEN-1:0] mcause_val;

`ifdef RISCV_NMI_EN
   assign nmi_req = bus.nmi;
`else
   assign nmi_req = 1'b0;
`endif

   assign irq_live = bus.irq_pending & IRQ_MASK;
   assign irq_take = (irq_live != '0) && ((bus.priv < PRV_M) || bus.mstatus_mie);
   assign vec_base = {bus.mtvec[XLEN-1:2], 2'b00};

   // Highest-priority pending interrupt: MEI MSI MTI SEI SSI STI UEI USI UTI
   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      irq_cause = 4'd0;
      if      (irq_live[11]) irq_cause = 4'd11;
      else if (irq_live[3])  irq_cause = 4'd3;
      else if (irq_live[7])  irq_cause = 4'd7;
      else if (irq_live[9])  irq_cause = 4'd9;
      else if (irq_live[1])  irq_cause = 4'd1;
      else if (irq_live[5])  irq_cause = 4'd5;
      else if (irq_live[8])  irq_cause = 4'd8;
      else if (irq_live[0])  irq_cause = 4'd0;
      else if (irq_live[4])  irq_cause = 4'd4;
   end

   // Event arbitration: NMI > exception > MRET > interrupt
   always_comb begin
      ev_sel   = EV_EXC;
      evt_take = 1'b1;
      if      (nmi_req)        ev_sel = EV_NMI;
      else if (bus.exc_valid)  ev_sel = EV_EXC;
      else if (bus.mret_valid) ev_sel = EV_MRET;
      else if (irq_take)       ev_sel = EV_IRQ;
      else                     evt_take = 1'b0;
   end

   // Redirect target, evaluated in COMMIT and frozen for the REDIR phase
   always_comb begin
      target_d = PC_INIT;
      case (ev_q)
         EV_EXC:  target_d = vec_base;
         EV_IRQ:  target_d = (bus.mtvec[1:0] == 2'b01)
                             ? vec_base + XLEN'({cause_q, 2'b00})
                             : vec_base;
         EV_MRET: target_d = bus.mepc;
`ifdef RISCV_NMI_EN
         EV_NMI:  target_d = bus.mnmivec;
`else
         EV_NMI:  target_d = PC_INIT;
`endif
         default: target_d = PC_INIT;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (evt_take)        state_d = S_DRAIN;
         S_DRAIN:  if (bus.drained)     state_d = S_COMMIT;
         S_COMMIT:                      state_d = S_REDIR;
         S_REDIR:  if (bus.redir_ready) state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // Event capture in IDLE and redirect-target capture in COMMIT
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ev_q     <= EV_EXC;
         cause_q  <= '0;
         pc_q     <= '0;
         tval_q   <= '0;
         target_q <= '0;
      end else begin
         if (state_q == S_IDLE && evt_take) begin
            ev_q    <= ev_sel;
            pc_q    <= bus.exc_pc;
            cause_q <= (ev_sel == EV_IRQ) ? irq_cause :
                       (ev_sel == EV_EXC) ? bus.exc_cause : 4'd0;
            tval_q  <= (ev_sel == EV_EXC) ? bus.exc_tval : '0;
         end
         if (state_q == S_COMMIT) target_q <= target_d;
      end
   end

   // Trap cause: interrupt flag in the MSB, cause code in the low bits
   always_comb begin
      mcause_val           = XLEN'(cause_q);
      mcause_val[XLEN-1]   = (ev_q != EV_EXC);
   end

   // Outputs decoded from the current state
   always_comb begin
      bus.evt_ready   = 1'b0;
      bus.flush       = 1'b0;
      bus.csr_we      = 1'b0;
      bus.mepc_d      = '0;
      bus.mcause_d    = '0;
      bus.mtval_d     = '0;
      bus.mie_d       = 1'b0;
      bus.mpie_d      = 1'b0;
      bus.mpp_d       = PRV_U;
      bus.priv_d      = PRV_U;
      bus.redir_valid = 1'b0;
      bus.redir_pc    = '0;
      case (state_q)
         S_IDLE:  bus.evt_ready = 1'b1;
         S_DRAIN: bus.flush     = 1'b1;
         S_COMMIT: begin
            bus.csr_we = 1'b1;
            if (ev_q == EV_MRET) begin
               // mepc passes through unchanged; mcause/mtval are not updated
               bus.mepc_d = bus.mepc;
               bus.mie_d  = bus.mstatus_mpie;
               bus.mpie_d = 1'b1;
               bus.priv_d = bus.mstatus_mpp;
               bus.mpp_d  = PRV_U;
            end else begin
               bus.mepc_d   = {pc_q[XLEN-1:2], 2'b00};
               bus.mcause_d = mcause_val;
               bus.mtval_d  = tval_q;
               bus.mie_d    = 1'b0;
               bus.mpie_d   = bus.mstatus_mie;
               bus.mpp_d    = bus.priv;
               bus.priv_d   = PRV_M;
            end
         end
         S_REDIR: begin
            bus.redir_valid = 1'b1;
            bus.redir_pc    = target_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Self-checking bench for riscv_trap_ctrl (default build, XLEN=32).
// Expected results come from a behavioural model of the trap rules.
module tb_riscv_trap_ctrl;

   localparam int          XLEN     = 32;
   localparam logic [11:0] IRQ_BITS = 12'hBBB;

   typedef struct packed {
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic [31:0] mtval;
      logic        mie;
      logic        mpie;
      logic [1:0]  mpp;
      logic [1:0]  priv;
   } csr_t;

   typedef struct {
      bit        exc_valid;
      bit [3:0]  exc_cause;
      bit [31:0] exc_pc;
      bit [31:0] exc_tval;
      bit        mret_valid;
      bit [11:0] irq;
      bit        mie;
      bit        mpie;
      bit [1:0]  mpp;
      bit [1:0]  priv;
      bit [31:0] mtvec;
      bit [31:0] mepc;
   } stim_t;

   typedef struct {
      bit          take;
      bit          is_mret;
      csr_t        csr;
      logic [31:0] redir;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   riscv_trap_ctrl_if #(.XLEN(XLEN)) bus ();

   riscv_trap_ctrl #(.XLEN(XLEN), .PC_INIT(32'h200)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Reference model: what a trap/MRET does to the CSRs and where fetch goes
   function automatic exp_t model(input stim_t s);
      exp_t        e;
      int          order [9];
      int          cause;
      bit          found;
      bit          irq_ok;
      logic [31:0] base;
      order   = '{11, 3, 7, 9, 1, 5, 8, 0, 4};
      e.take    = 1'b1;
      e.is_mret = 1'b0;
      e.csr     = '0;
      e.redir   = '0;
      base      = s.mtvec & ~32'h3;
      irq_ok    = (s.irq != 0) && (s.priv < 2'd3 || s.mie);
      if (s.exc_valid) begin
         e.csr.mepc   = s.exc_pc & ~32'h3;
         e.csr.mcause = 32'(s.exc_cause);
         e.csr.mtval  = s.exc_tval;
         e.csr.mpie   = s.mie;
         e.csr.mpp    = s.priv;
         e.csr.priv   = 2'd3;
         e.redir      = base;
      end else if (s.mret_valid) begin
         e.is_mret    = 1'b1;
         e.csr.mepc   = s.mepc;
         e.csr.mie    = s.mpie;
         e.csr.mpie   = 1'b1;
         e.csr.priv   = s.mpp;
         e.csr.mpp    = 2'd0;
         e.redir      = s.mepc;
      end else if (irq_ok) begin
         cause = 0;
         found = 1'b0;
         for (int i = 0; i < 9; i++) begin
            if (!found && s.irq[order[i]]) begin
               cause = order[i];
               found = 1'b1;
            end
         end
         e.csr.mepc   = s.exc_pc & ~32'h3;
         e.csr.mcause = 32'h8000_0000 | 32'(cause);
         e.csr.mpie   = s.mie;
         e.csr.mpp    = s.priv;
         e.csr.priv   = 2'd3;
         e.redir      = (s.mtvec[1:0] == 2'b01) ? base + 32'(4 * cause) : base;
      end else begin
         e.take = 1'b0;
      end
      return e;
   endfunction

   function automatic stim_t blank();
      stim_t s;
      s.exc_valid = 0; s.exc_cause = 0; s.exc_pc = 0; s.exc_tval = 0;
      s.mret_valid = 0; s.irq = 0; s.mie = 0; s.mpie = 0; s.mpp = 0;
      s.priv = 2'd3; s.mtvec = 0; s.mepc = 0;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      bus.exc_valid    = s.exc_valid;
      bus.exc_cause    = s.exc_cause;
      bus.exc_pc       = s.exc_pc;
      bus.exc_tval     = s.exc_tval;
      bus.mret_valid   = s.mret_valid;
      bus.irq_pending  = s.irq;
      bus.mstatus_mie  = s.mie;
      bus.mstatus_mpie = s.mpie;
      bus.mstatus_mpp  = s.mpp;
      bus.priv         = s.priv;
      bus.mtvec        = s.mtvec;
      bus.mepc         = s.mepc;
   endtask

   // Event inputs outside IDLE: either quiet or random noise to be ignored
   task automatic drive_events(input bit junk);
      bus.exc_valid   = junk ? 1'($urandom) : 1'b0;
      bus.exc_cause   = junk ? 4'($urandom) : 4'd0;
      bus.exc_pc      = junk ? $urandom : 32'd0;
      bus.exc_tval    = junk ? $urandom : 32'd0;
      bus.mret_valid  = junk ? 1'($urandom) : 1'b0;
      bus.irq_pending = junk ? (12'($urandom) & IRQ_BITS) : 12'd0;
   endtask

   // One full event: offer in IDLE, drain, commit, redirect, back to IDLE
   task automatic run_txn(input stim_t s, input int drain_dly, input int ready_dly,
                          input bit junk, input string name);
      exp_t e;
      csr_t act;
      e = model(s);
      @(negedge clk);
      checks++;
      if (bus.evt_ready !== 1'b1) begin
         errors++; $display("FAIL %s idle_ready: got %b want 1", name, bus.evt_ready);
      end
      apply(s);
      bus.drained     = 1'b0;
      bus.redir_ready = 1'b0;
      @(negedge clk);
      if (!e.take) begin
         drive_events(1'b0);
         checks++;
         if (bus.flush !== 1'b0 || bus.evt_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s no_take: flush=%b evt_ready=%b want flush=0 evt_ready=1",
                     name, bus.flush, bus.evt_ready);
         end
         return;
      end
      for (int i = 0; i <= drain_dly; i++) begin
         checks++;
         if ({bus.flush, bus.evt_ready, bus.csr_we} !== 3'b100) begin
            errors++;
            $display("FAIL %s drain[%0d]: flush/ready/we=%b want 100", name, i,
                     {bus.flush, bus.evt_ready, bus.csr_we});
         end
         if (i == drain_dly) bus.drained = 1'b1;
         drive_events(junk);
         @(negedge clk);
      end
      bus.drained = 1'b0;
      checks++;
      if (bus.csr_we !== 1'b1 || bus.flush !== 1'b0) begin
         errors++;
         $display("FAIL %s commit_we: csr_we=%b flush=%b want 1 0", name, bus.csr_we, bus.flush);
      end
      act = '{bus.mepc_d, bus.mcause_d, bus.mtval_d, bus.mie_d, bus.mpie_d, bus.mpp_d, bus.priv_d};
      if (e.is_mret) begin
         act.mcause = '0;
         act.mtval  = '0;
      end
      checks++;
      if (act !== e.csr) begin
         errors++;
         $display("FAIL %s commit_csr: got %h want %h", name, act, e.csr);
      end
      @(negedge clk);
      for (int i = 0; i <= ready_dly; i++) begin
         checks++;
         if (bus.redir_valid !== 1'b1 || bus.redir_pc !== e.redir || bus.csr_we !== 1'b0) begin
            errors++;
            $display("FAIL %s redir[%0d]: valid=%b pc=%h we=%b want 1 %h 0", name, i,
                     bus.redir_valid, bus.redir_pc, bus.csr_we, e.redir);
         end
         if (i == ready_dly) begin
            bus.redir_ready = 1'b1;
            drive_events(1'b0);
         end else begin
            drive_events(junk);
         end
         @(negedge clk);
      end
      bus.redir_ready = 1'b0;
      checks++;
      if (bus.redir_valid !== 1'b0 || bus.evt_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s back_idle: valid=%b ready=%b want 0 1", name,
                  bus.redir_valid, bus.evt_ready);
      end
   endtask

   task automatic test_reset();
      apply(blank());
      bus.exc_valid   = 1'b1;
      bus.drained     = 1'b1;
      bus.redir_ready = 1'b0;
`ifdef RISCV_NMI_EN
      bus.nmi     = 1'b0;
      bus.mnmivec = '0;
`endif
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.evt_ready, bus.flush, bus.csr_we, bus.redir_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 1000",
                  {bus.evt_ready, bus.flush, bus.csr_we, bus.redir_valid});
      end
      checks++;
      if ({bus.mepc_d, bus.mcause_d, bus.mtval_d, bus.redir_pc} !== '0 ||
          {bus.mie_d, bus.mpie_d, bus.mpp_d, bus.priv_d} !== 6'd0) begin
         errors++;
         $display("FAIL reset_data: got %h want 0",
                  {bus.mepc_d, bus.mcause_d, bus.mtval_d, bus.redir_pc});
      end
      bus.exc_valid = 1'b0;
      bus.drained   = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.evt_ready !== 1'b1 || bus.flush !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b flush=%b want 1 0", bus.evt_ready, bus.flush);
      end
   endtask

   task automatic test_directed();
      stim_t s;
      // Exception with tval
      s = blank();
      s.exc_valid = 1; s.exc_cause = 4'd2; s.exc_pc = 32'h100; s.exc_tval = 32'hDEAD;
      s.mtvec = 32'h400; s.mie = 1;
      run_txn(s, 2, 0, 0, "exception");
      // Vectored machine timer interrupt
      s = blank();
      s.irq = 12'h080; s.mie = 1; s.mtvec = 32'h401; s.exc_pc = 32'h304;
      run_txn(s, 1, 0, 0, "vectored_mti");
      // Same interrupt masked in M-mode
      s.mie = 0;
      run_txn(s, 0, 0, 0, "masked_irq");
      // Masked bit ignored below M-mode
      s = blank();
      s.irq = 12'h002; s.priv = 2'd0; s.mtvec = 32'h801; s.exc_pc = 32'h1236;
      run_txn(s, 0, 1, 0, "umode_ssi");
      // MRET to user mode
      s = blank();
      s.mret_valid = 1; s.mpie = 1; s.mpp = 2'd0; s.mepc = 32'h2000;
      run_txn(s, 0, 0, 0, "mret");
      // Vector address wraps at the top of the address space
      s = blank();
      s.irq = 12'h800; s.mie = 1; s.mtvec = 32'hFFFF_FFFD; s.exc_pc = 32'h40;
      run_txn(s, 0, 0, 0, "vector_wrap");
   endtask

   task automatic test_backpressure_priority();
      stim_t s;
      s = blank();
      s.exc_valid = 1; s.exc_cause = 4'd5; s.exc_pc = 32'h5550; s.exc_tval = 32'h1234;
      s.irq = 12'h800; s.mie = 1; s.mtvec = 32'h401;
      run_txn(s, 3, 5, 1, "backpressure_exc_vs_mei");
   endtask

   task automatic test_reset_mid_drain();
      stim_t s;
      int    we_seen;
      s = blank();
      s.exc_valid = 1; s.exc_cause = 4'd7; s.exc_pc = 32'h900; s.mtvec = 32'h400;
      @(negedge clk);
      apply(s);
      @(negedge clk);
      drive_events(1'b0);
      checks++;
      if (bus.flush !== 1'b1) begin
         errors++; $display("FAIL mid_drain_flush: got %b want 1", bus.flush);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({bus.evt_ready, bus.flush, bus.csr_we, bus.redir_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL mid_drain_abort: got %b want 1000",
                  {bus.evt_ready, bus.flush, bus.csr_we, bus.redir_valid});
      end
      bus.drained = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      we_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.csr_we === 1'b1 || bus.flush === 1'b1) we_seen++;
      end
      bus.drained = 1'b0;
      checks++;
      if (we_seen != 0) begin
         errors++; $display("FAIL mid_drain_no_commit: got %0d busy cycles want 0", we_seen);
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int n = 0; n < 40; n++) begin
         s = blank();
         s.exc_valid  = ($urandom_range(0, 9) < 3);
         s.exc_cause  = 4'($urandom);
         s.exc_pc     = $urandom;
         s.exc_tval   = $urandom;
         s.mret_valid = ($urandom_range(0, 9) < 3);
         s.irq        = ($urandom_range(0, 3) != 0) ? (12'($urandom) & IRQ_BITS) : 12'd0;
         s.mie        = 1'($urandom);
         s.mpie       = 1'($urandom);
         s.mpp        = 2'($urandom);
         s.priv       = 2'($urandom);
         s.mtvec      = $urandom;
         s.mepc       = $urandom;
         run_txn(s, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), "random");
      end
   endtask

   initial begin
      bus.drained     = 1'b0;
      bus.redir_ready = 1'b0;
      test_reset();
      test_directed();
      test_backpressure_priority();
      test_reset_mid_drain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_trap_ctrl.md
RISCV_TRAP_CTRL -- requirements
Module: riscv_trap_ctrl

Interface
REQ-001 Parameter XLEN, default 32, sets the data/address width; only 32 and 64 are legal.
REQ-002 Parameter PC_INIT, default 'h200, is the redirect target used after reset when no trap is taken.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 exc_valid  in  1  synchronous exception reported by the pipeline.
REQ-006 exc_cause  in  4  exception cause code, 0..15, using the 1.10 cause encoding.
REQ-007 exc_pc, exc_tval  in  XLEN  faulting PC and trap value.
REQ-008 mret_valid  in  1  an MRET instruction has retired.
REQ-009 irq_pending  in  12  mip AND mie, bit positions USI..MEI.
REQ-010 mstatus_mie, mstatus_mpie  in  1; mstatus_mpp  in  2; priv  in  2  current state.
REQ-011 mtvec, mepc  in  XLEN  current CSR values; mtvec[1:0] is the mode.
REQ-012 nmi  in  1  non-maskable interrupt, level-sensitive (present only with the configuration macro).
REQ-013 evt_ready  out  1  the block accepts exc/mret/irq events this cycle.
REQ-014 flush  out  1  pipeline flush request.
REQ-015 drained  in  1  the pipeline is empty after flush.
REQ-016 csr_we  out  1  one-cycle strobe that writes the following outputs.
REQ-017 mepc_d, mcause_d, mtval_d  out  XLEN  values written by csr_we.
REQ-018 mie_d, mpie_d  out  1; mpp_d, priv_d  out  2  values written by csr_we.
REQ-019 redir_valid  out  1; redir_pc  out  XLEN; redir_ready  in  1  fetch redirect handshake.

Function
REQ-020 The FSM states are IDLE, DRAIN, COMMIT, REDIR.
REQ-021 In IDLE, evt_ready=1; on a qualifying event the block latches the event, cause, PC and tval, then moves to DRAIN; all other outputs are 0.
REQ-022 An interrupt qualifies when irq_pending!=0 and (priv<PRV_M or mstatus_mie=1).
REQ-023 Event priority: NMI > exception > MRET > interrupt.
REQ-024 Interrupt priority: MEI > MSI > MTI > SEI > SSI > STI > UEI > USI > UTI.
REQ-025 In DRAIN, flush=1 is held until drained=1, then the FSM moves to COMMIT.
REQ-026 In COMMIT, csr_we=1 for exactly one cycle, then the FSM moves to REDIR.
REQ-027 Trap COMMIT outputs: mepc_d=latched PC with bits [1:0] zero; mpie_d=mstatus_mie; mie_d=0; mpp_d=priv; priv_d=PRV_M.
REQ-028 mcause_d for an interrupt: bit XLEN-1=1 and the low bits hold the interrupt cause.
REQ-029 mcause_d for an exception: bit XLEN-1=0 and the low bits hold exc_cause.
REQ-030 mtval_d for an exception is exc_tval; for an interrupt it is 0.
REQ-031 MRET COMMIT outputs: mie_d=mstatus_mpie; mpie_d=1; priv_d=mstatus_mpp; mpp_d=PRV_U; mepc_d, mcause_d and mtval_d are unchanged pass-through values and are not written.
REQ-032 redir_pc for an exception is {mtvec[XLEN-1:2],2'b00}.
REQ-033 redir_pc for an interrupt with mtvec mode=1 is base+4*cause; otherwise it is base.
REQ-034 redir_pc for an MRET is mepc.
REQ-035 In REDIR, redir_valid=1 and redir_pc are held stable until redir_ready=1; the FSM returns to IDLE in the same cycle that redir_ready=1.
REQ-036 Events arriving while the FSM is not in IDLE are ignored; the pipeline must hold them because evt_ready=0.
REQ-037 The address arithmetic is XLEN bits wide; overflow wraps silently.

Reset
REQ-038 While rstn=0, the FSM is in IDLE, all outputs are 0 except evt_ready=1, and all latches are 0.
REQ-039 An assertion of reset in any state aborts the operation with no csr_we pulse; after release the FSM is in IDLE.

Configuration
REQ-040 Macro RISCV_NMI_EN: when defined, the nmi port exists and NMI takes the highest priority.
REQ-041 With RISCV_NMI_EN, an NMI COMMIT uses mcause_d=0 with bit XLEN-1=1, and redir_pc is the MNMIVEC value supplied on input mnmivec (XLEN).
REQ-042 Without RISCV_NMI_EN, neither the nmi port nor the mnmivec port exists and NMI logic is absent.

Verification
REQ-043 Exception: exc_valid=1, exc_cause=2, exc_pc='h100, exc_tval='hDEAD, mtvec='h400 -> flush until drained; csr_we with mepc_d='h100, mcause_d=2, mtval_d='hDEAD; redir_pc='h400.
REQ-044 Vectored interrupt: mtvec='h401, irq_pending bit MTI set, priv=PRV_M, mie=1 -> mcause_d='h80000007; redir_pc='h41C.
REQ-045 Masked interrupt: same stimulus as REQ-044 with mie=0 and priv=PRV_M -> no flush, evt_ready stays 1.
REQ-046 MRET: mpie=1, mpp=PRV_U, mepc='h2000 -> mie_d=1, priv_d=0, mpp_d=0, redir_pc='h2000.
REQ-047 Backpressure and priority: redir_ready held low for 5 cycles -> redir_valid and redir_pc stable; a simultaneous exc_valid+MEI takes the exception.
REQ-048 Reset mid-DRAIN: rstn=0 -> immediate return to IDLE, no csr_we pulse.
